// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serialising memory controller.
`timescale 1ns/1ps
package mem_ctrl_pkg;

  localparam int unsigned AddressWidth     = 32;
  localparam int unsigned InstructionWidth = 32;

  // Request size encodings (byte count).
  localparam logic [2:0] SizeByte = 3'd1;
  localparam logic [2:0] SizeHalf = 3'd2;
  localparam logic [2:0] SizeWord = 3'd4;

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;
  typedef enum logic {OwnIf, OwnLsb} owner_e;

  // Unsupported sizes fall back to a full word so the step counter stays in range.
  function automatic logic [2:0] size_to_n(input logic [2:0] size);
    case (size)
      SizeByte: return SizeByte;
      SizeHalf: return SizeHalf;
      default:  return SizeWord;
    endcase
  endfunction

  function automatic logic [31:0] merge_byte(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [7:0] b);
    logic [31:0] res;
    res = word;
    res[{lane, 3'b000} +: 8] = b;
    return res;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Serialises fetch and load/store requests into single-byte RAM accesses;
// LSB has priority, stores always complete, reads abort on rob_clear_in.
`timescale 1ns/1ps
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = AddressWidth,
  parameter int unsigned DATA_W = InstructionWidth
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              if_en_in,
  input  logic [ADDR_W-1:0] if_pc_in,
  output logic              if_rdy_out,
  output logic              if_done_out,
  output logic [DATA_W-1:0] if_inst_out,
  input  logic              lsb_en_in,
  input  logic              lsb_wr_in,
  input  logic [ADDR_W-1:0] lsb_addr_in,
  input  logic [2:0]        lsb_size_in,
  input  logic [DATA_W-1:0] lsb_data_in,
  output logic              lsb_done_out,
  output logic [DATA_W-1:0] lsb_data_out,
  input  logic              rob_clear_in
);

  state_e              state_q;
  owner_e              owner_q;
  logic [ADDR_W-1:0]   base_q;
  logic [2:0]          nbytes_q;
  logic [2:0]          step_q;
  logic [DATA_W-1:0]   asm_q;
  logic [DATA_W-1:0]   merged;
  logic [1:0]          rd_lane;

  assign if_rdy_out = (state_q == StIdle);

  // The byte on mem_din at step k belongs to the address issued at step k-2.
  always_comb begin
    rd_lane = step_q[1:0] - 2'd2;
    merged  = merge_byte(asm_q, rd_lane, mem_din);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= StIdle;
      owner_q      <= OwnIf;
      base_q       <= '0;
      nbytes_q     <= '0;
      step_q       <= '0;
      asm_q        <= '0;
      mem_a        <= '0;
      mem_dout     <= '0;
      mem_wr       <= 1'b0;
      if_done_out  <= 1'b0;
      if_inst_out  <= '0;
      lsb_done_out <= 1'b0;
      lsb_data_out <= '0;
    end else if (rdy_in) begin
      if_done_out  <= 1'b0;
      lsb_done_out <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!rob_clear_in && lsb_en_in) begin
            owner_q  <= OwnLsb;
            base_q   <= lsb_addr_in;
            nbytes_q <= size_to_n(lsb_size_in);
            step_q   <= 3'd1;
            mem_a    <= lsb_addr_in;
            if (lsb_wr_in) begin
              state_q  <= StWrite;
              asm_q    <= lsb_data_in;
              mem_dout <= lsb_data_in[7:0];
              mem_wr   <= 1'b1;
            end else begin
              state_q <= StRead;
              asm_q   <= '0;
              mem_wr  <= 1'b0;
            end
          end else if (!rob_clear_in && if_en_in) begin
            owner_q  <= OwnIf;
            base_q   <= if_pc_in;
            nbytes_q <= SizeWord;
            step_q   <= 3'd1;
            mem_a    <= if_pc_in;
            asm_q    <= '0;
            mem_wr   <= 1'b0;
            state_q  <= StRead;
          end
        end
        StRead: begin
          if (rob_clear_in) begin
            state_q <= StIdle;
          end else begin
            if (step_q < nbytes_q) mem_a <= base_q + ADDR_W'(step_q);
            if (step_q == nbytes_q + 3'd1) begin
              state_q <= StIdle;
              if (owner_q == OwnLsb) begin
                lsb_data_out <= merged;
                lsb_done_out <= 1'b1;
              end else begin
                if_inst_out <= merged;
                if_done_out <= 1'b1;
              end
            end else if (step_q >= 3'd2) begin
              asm_q <= merged;
            end
            step_q <= step_q + 3'd1;
          end
        end
        StWrite: begin
          if (step_q == nbytes_q) begin
            mem_wr       <= 1'b0;
            lsb_done_out <= 1'b1;
            state_q      <= StIdle;
          end else begin
            mem_a    <= base_q + ADDR_W'(step_q);
            mem_dout <= get_byte(asm_q, step_q[1:0]);
          end
          step_q <= step_q + 3'd1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
